// File: rtl/eqa_pkg.sv
// Shared types and constants for the EQ band coefficient loader.
// Coefficients are Q2.16 in 18 bits; the state enum is shared with the bench.
package eqa_pkg;

    typedef logic signed [17:0] coeff_t;

    localparam coeff_t     COEFF_ONE = 18'h10000;
    localparam logic [7:0] EQA_HDR   = 8'hA5;
    localparam int         NUM_COEFF = 6;
    localparam int         PAY_BYTES = 18;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BAND,
        ST_PAY,
        ST_CHK,
        ST_PEND
    } eqa_state_e;

endpackage

// File: rtl/eqa_byte_timeout.sv
// Inter-byte watchdog: counts consecutive enabled cycles without a clear.
// o_expire is high on the TIMEOUT_CYC-th such cycle; the counter then restarts.
module eqa_byte_timeout #(
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] r_cnt;

    assign o_expire = i_en && !i_clr && (r_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en || o_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/eqa_coeff_loader.sv
// Assembles one biquad band's coefficient set from a 21-byte frame, commits it
// with coeff_we, then applies it with coeff_set on the next audio sample tick.
module eqa_coeff_loader
    import eqa_pkg::*;
#(
    parameter int         BAND_ID     = 3,
    parameter logic [7:0] HDR         = EQA_HDR,
    parameter int         TIMEOUT_CYC = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    input  logic       sample_tick,
    output coeff_t     Eqa_A_0,
    output coeff_t     Eqa_A_1,
    output coeff_t     Eqa_A_2,
    output coeff_t     Eqa_B_0,
    output coeff_t     Eqa_B_1,
    output coeff_t     Eqa_B_2,
    output logic       coeff_we,
    output logic       coeff_set,
    output logic       EQA_flag,
    output logic       err
);

    eqa_state_e r_state;
    logic       r_s_ready;
    logic       r_coeff_we;
    logic       r_coeff_set;
    logic       r_flag;
    logic       r_err;
    logic [7:0] r_band;
    logic [7:0] r_csum;
    logic [4:0] r_pay_cnt;
    logic [7:0] r_shadow [PAY_BYTES];
    coeff_t     r_coeff  [NUM_COEFF];

    logic       w_accept;
    logic       w_expire;
    logic       w_to_en;
    coeff_t     w_shadow_coeff [NUM_COEFF];

    assign w_accept = s_valid && r_s_ready;
    assign w_to_en  = (r_state == ST_BAND) || (r_state == ST_PAY) || (r_state == ST_CHK);

    eqa_byte_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_accept),
        .i_en     (w_to_en),
        .o_expire (w_expire)
    );

    // Payload order is B_0,B_1,B_2,A_0,A_1,A_2; only the low 2 bits of each lead byte count.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_COEFF; gi++) begin : g_pack
            assign w_shadow_coeff[gi] = {r_shadow[3*gi][1:0], r_shadow[3*gi+1], r_shadow[3*gi+2]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (r_state == ST_PAY && w_accept) begin
            r_shadow[r_pay_cnt] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_s_ready   <= 1'b1;
            r_coeff_we  <= 1'b0;
            r_coeff_set <= 1'b0;
            r_flag      <= 1'b0;
            r_err       <= 1'b0;
            r_band      <= '0;
            r_csum      <= '0;
            r_pay_cnt   <= '0;
            for (int i = 0; i < NUM_COEFF; i++) begin
                r_coeff[i] <= (i == 0 || i == 3) ? COEFF_ONE : '0;
            end
        end else begin
            r_coeff_we  <= 1'b0;
            r_coeff_set <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && s_data == HDR) begin
                        r_state <= ST_BAND;
                    end
                end
                ST_BAND: begin
                    if (w_accept) begin
                        r_band    <= s_data;
                        r_csum    <= s_data;
                        r_pay_cnt <= '0;
                        r_state   <= ST_PAY;
                    end else if (w_expire) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_PAY: begin
                    if (w_accept) begin
                        r_csum <= r_csum ^ s_data;
                        if (r_pay_cnt == 5'(PAY_BYTES - 1)) begin
                            r_state <= ST_CHK;
                        end else begin
                            r_pay_cnt <= r_pay_cnt + 1'b1;
                        end
                    end else if (w_expire) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_CHK: begin
                    if (w_accept) begin
                        if (s_data != r_csum) begin
                            r_err   <= 1'b1;
                            r_state <= ST_IDLE;
                        end else if (r_band == 8'(BAND_ID)) begin
                            for (int i = 0; i < NUM_COEFF; i++) begin
                                r_coeff[i] <= w_shadow_coeff[i];
                            end
                            r_coeff_we <= 1'b1;
                            r_flag     <= 1'b1;
                            r_s_ready  <= 1'b0;
                            r_state    <= ST_PEND;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_expire) begin
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                ST_PEND: begin
                    // A tick landing in the commit cycle itself is too early to apply.
                    if (r_coeff_set) begin
                        r_flag    <= 1'b0;
                        r_s_ready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else if (sample_tick && !r_coeff_we) begin
                        r_coeff_set <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready   = r_s_ready;
    assign coeff_we  = r_coeff_we;
    assign coeff_set = r_coeff_set;
    assign EQA_flag  = r_flag;
    assign err       = r_err;
    assign Eqa_B_0   = r_coeff[0];
    assign Eqa_B_1   = r_coeff[1];
    assign Eqa_B_2   = r_coeff[2];
    assign Eqa_A_0   = r_coeff[3];
    assign Eqa_A_1   = r_coeff[4];
    assign Eqa_A_2   = r_coeff[5];

endmodule

// File: tb/tb_eqa_coeff_loader.sv
// Scoreboard bench for eqa_coeff_loader: frame stimulus pushes expected events,
// a negedge monitor pops them and tracks the committed coefficient model.
module tb_eqa_coeff_loader;
    import eqa_pkg::*;

    localparam int TO = 200;
    localparam logic [107:0] RST_CO = {18'h10000, 18'h0, 18'h0, 18'h10000, 18'h0, 18'h0};
    // Order: B_0, B_1, B_2, A_0, A_1, A_2
    localparam logic [107:0] C1 = {18'h0C000, 18'h3E000, 18'h01000, 18'h10000, 18'h38000, 18'h02000};
    localparam logic [107:0] C2 = {18'h01234, 18'h2ABCD, 18'h3FFFF, 18'h20000, 18'h00001, 18'h1FFFF};
    localparam logic [107:0] C3 = {18'h05555, 18'h3AAAA, 18'h00F0F, 18'h10000, 18'h31234, 18'h0ABCD};
    localparam logic [107:0] C4 = {18'h3FFFF, 18'h00000, 18'h12345, 18'h0FFFF, 18'h2FEDC, 18'h00100};

    localparam int K_WE  = 0;
    localparam int K_ERR = 1;
    localparam int K_SET = 2;

    typedef struct {
        int           kind;
        int           cyc;
        logic [107:0] co;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready;
    logic       sample_tick = 1'b0;
    coeff_t     Eqa_A_0, Eqa_A_1, Eqa_A_2, Eqa_B_0, Eqa_B_1, Eqa_B_2;
    logic       coeff_we, coeff_set, EQA_flag, err;

    int   cyc = 0;
    int   extra_tick = -1;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    exp_t sb_q[$];
    logic [107:0] model_co = RST_CO;
    bit   flag_exp = 1'b0;
    bit   flag_drop = 1'b0;

    eqa_coeff_loader #(
        .BAND_ID     (3),
        .HDR         (8'hA5),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .sample_tick (sample_tick),
        .Eqa_A_0     (Eqa_A_0),
        .Eqa_A_1     (Eqa_A_1),
        .Eqa_A_2     (Eqa_A_2),
        .Eqa_B_0     (Eqa_B_0),
        .Eqa_B_1     (Eqa_B_1),
        .Eqa_B_2     (Eqa_B_2),
        .coeff_we    (coeff_we),
        .coeff_set   (coeff_set),
        .EQA_flag    (EQA_flag),
        .err         (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(negedge clk);
            sample_tick = ((cyc % 100) == 50) || (cyc == extra_tick);
        end
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int next_tick(input int after);
        for (int c = after + 1; c < after + 1000; c++) begin
            if ((c % 100) == 50 || c == extra_tick) return c;
        end
        return -1;
    endfunction

    task automatic pop_check(input int kind);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("unexpected_event", 128'(kind), 128'hFF);
            return;
        end
        e = sb_q.pop_front();
        check_eq("event_kind", 128'(kind), 128'(e.kind));
        check_eq("event_cycle", 128'(cyc), 128'(e.cyc));
        $display("event kind=%0d at cycle %0d (expected kind=%0d cycle %0d)", kind, cyc, e.kind, e.cyc);
        if (kind == K_WE) begin
            model_co = e.co;
            flag_exp = 1'b1;
        end else if (kind == K_SET) begin
            flag_drop = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                sb_q.delete();
                model_co  = RST_CO;
                flag_exp  = 1'b0;
                flag_drop = 1'b0;
            end else begin
                if (flag_drop) begin
                    flag_exp  = 1'b0;
                    flag_drop = 1'b0;
                end
                if (err)       pop_check(K_ERR);
                if (coeff_we)  pop_check(K_WE);
                if (coeff_set) pop_check(K_SET);
            end
            check_eq("coeffs", 128'({Eqa_B_0, Eqa_B_1, Eqa_B_2, Eqa_A_0, Eqa_A_1, Eqa_A_2}), 128'(model_co));
            check_eq("eqa_flag", 128'(EQA_flag), 128'(flag_exp));
            check_eq("s_ready", 128'(s_ready), 128'(!flag_exp));
        end
    end

    task automatic send_byte(input logic [7:0] b, output int acc);
        int waited = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) check_eq("ready_wait", 128'(s_ready), 128'(1));
        acc = cyc;
        @(posedge clk);
    endtask

    task automatic push_exp(input int kind, input int at, input logic [107:0] co);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        e.co   = co;
        sb_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] band, input logic [107:0] co,
                              input logic [7:0] cx, input bit tick_at_we);
        logic [7:0]  fb [21];
        logic [7:0]  cs;
        logic [17:0] c;
        int          acc;
        fb[0] = 8'hA5;
        fb[1] = band;
        cs    = band;
        for (int i = 0; i < 6; i++) begin
            c = co[107 - 18*i -: 18];
            fb[2 + 3*i] = {6'b101101, c[17:16]};
            fb[3 + 3*i] = c[15:8];
            fb[4 + 3*i] = c[7:0];
            cs = cs ^ fb[2 + 3*i] ^ fb[3 + 3*i] ^ fb[4 + 3*i];
        end
        fb[20] = cs ^ cx;
        for (int i = 0; i < 21; i++) begin
            send_byte(fb[i], acc);
            if (i == 0 && tick_at_we) extra_tick = acc + 21;
        end
        if (cx != 8'h00) begin
            push_exp(K_ERR, acc + 1, '0);
        end else if (band == 8'd3) begin
            push_exp(K_WE, acc + 1, co);
            push_exp(K_SET, next_tick(acc + 1) + 1, '0);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (sb_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain", 128'(sb_q.size()), 128'(0));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic [7:0] cs;
        logic [7:0] pb [8];

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_s_ready", 128'(s_ready), 128'(1));
        check_eq("rst_flag", 128'(EQA_flag), 128'(0));
        check_eq("rst_we", 128'(coeff_we), 128'(0));
        check_eq("rst_set", 128'(coeff_set), 128'(0));
        check_eq("rst_err", 128'(err), 128'(0));
        check_eq("rst_coeffs", 128'({Eqa_B_0, Eqa_B_1, Eqa_B_2, Eqa_A_0, Eqa_A_1, Eqa_A_2}), 128'(RST_CO));
        mon_en = 1'b1;

        // Bad checksum: err only, outputs keep reset values.
        send_frame(8'd3, C1, 8'h01, 1'b0);
        wait_drain(100);
        // Good band-3 frame.
        send_frame(8'd3, C1, 8'h00, 1'b0);
        wait_drain(300);
        // Foreign band is dropped silently; next band-3 frame commits.
        send_frame(8'd2, C2, 8'h00, 1'b0);
        repeat (5) @(negedge clk);
        send_frame(8'd3, C2, 8'h00, 1'b0);
        wait_drain(300);

        // Stall after payload byte 7.
        send_byte(8'hA5, acc);
        send_byte(8'd3, acc);
        for (int i = 0; i < 8; i++) begin
            pb[i] = 8'(8'h11 * (i + 1));
            send_byte(pb[i], acc);
        end
        push_exp(K_ERR, acc + TO + 1, '0);
        @(negedge clk);
        s_valid = 1'b0;
        wait_drain(TO + 50);
        send_frame(8'd3, C3, 8'h00, 1'b0);
        wait_drain(300);

        // Tick coincident with the commit cycle is ignored.
        send_frame(8'd3, C4, 8'h00, 1'b1);
        wait_drain(300);
        extra_tick = -1;

        // Reset while pending: update lost, no coeff_set afterwards.
        while ((cyc % 100) != 55) @(negedge clk);
        send_frame(8'd3, C1, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        check_eq("pend_queue", 128'(sb_q.size()), 128'(1));
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (150) @(negedge clk);
        cs = 8'h00;
        for (int i = 0; i < 4; i++) begin
            send_byte(8'(8'h3C + 8'h21 * i), acc);
        end
        @(negedge clk);
        s_valid = 1'b0;
        send_frame(8'd3, C2, 8'h00, 1'b0);
        wait_drain(300);

        check_eq("final_queue", 128'(sb_q.size()), 128'(0));
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
